io_input_debounce: RTL and testbench
====================================

IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving raw input bits per port; legal range 1..31.
REQ-002 The block SHALL have parameter DB_CYCLES, default 50000, giving the stable-cycle count required to accept a change; minimum 2.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port raw_in0, input, WIDTH bits: asynchronous switch/key inputs for port 0.
REQ-006 The block SHALL have port raw_in1, input, WIDTH bits: asynchronous switch/key inputs for port 1.
REQ-007 The block SHALL have port rd_en0, input, 1 bit: single-cycle strobe, MEM stage read of port 0.
REQ-008 The block SHALL have port rd_en1, input, 1 bit: single-cycle strobe, MEM stage read of port 1.
REQ-009 The block SHALL have port in_port0, output, 32 bits: {chg0, zeros, stable0[WIDTH-1:0]}, driven to the MEM stage's in_port0.
REQ-010 The block SHALL have port in_port1, output, 32 bits: same format as in_port0, for port 1.

Function
REQ-011 Each port SHALL pass raw_inN through a two-flop synchronizer (s1, s2) before any other use.
REQ-012 Each port SHALL hold a candidate register cand, a counter cnt, a stable register stable and a sticky flag chg.
REQ-013 When s2 != cand, the block SHALL load cand <= s2 and cnt <= 0.
REQ-014 When s2 == cand and cand == stable, the block SHALL hold cnt at 0.
REQ-015 When s2 == cand, cand != stable and cnt < DB_CYCLES-1, the block SHALL increment cnt.
REQ-016 When s2 == cand, cand != stable and cnt == DB_CYCLES-1, the block SHALL commit stable <= cand, set cnt <= 0 and set chg <= 1.
REQ-017 A bounce, meaning s2 differing from cand at any point during counting, SHALL restart counting from 0 with the new candidate; cnt SHALL never exceed DB_CYCLES-1 or wrap.
REQ-018 The latency from a clean raw change settling before edge k to the stable update SHALL be edge k+DB_CYCLES+2.
REQ-019 rd_enN SHALL clear chgN on the following edge.
REQ-020 When a commit and rd_enN occur on the same edge, the set SHALL win (chgN = 1).
REQ-021 in_portN SHALL be combinational from the registers: bit 31 = chgN, bits 30..WIDTH = 0, bits WIDTH-1..0 = stableN.
REQ-022 Ports 0 and 1 SHALL be fully independent; simultaneous activity on both SHALL have no interaction.

Reset
REQ-023 When resetn = 0 at a rising edge, the block SHALL clear s1, s2, cand, stable, cnt and chg on both ports to 0, so in_port0 = in_port1 = 32'h0.
REQ-024 A reset asserted mid-count SHALL abort the pending change; after release, a still-different raw input SHALL be re-debounced in full per REQ-018.
REQ-025 rd_enN SHALL be ignored while resetn = 0.

Configuration
REQ-026 Macro IO_DEBOUNCE_EN SHALL select the debounce implementation.
REQ-027 With IO_DEBOUNCE_EN defined, the block SHALL behave as REQ-012..REQ-018.
REQ-028 Without IO_DEBOUNCE_EN, cand and cnt SHALL be absent; stable <= s2 every edge; chg SHALL be set on any edge where s2 != stable; latency SHALL be edge k+2; DB_CYCLES SHALL be ignored.

Verification (WIDTH=10, DB_CYCLES=4, IO_DEBOUNCE_EN defined unless noted)
REQ-029 Reset scenario: hold resetn=0 with raw_in0=10'h3FF -> in_port0 = 32'h0; release, hold input -> in_port0 = 32'h800003FF six edges after release.
REQ-030 Clean change scenario: raw_in0 goes 0 -> 10'h155 before edge k -> in_port0 = 32'h0 through edge k+5 and 32'h80000155 after edge k+6.
REQ-031 Bounce scenario: raw_in1 toggles 0/10'h001 every 2 cycles for 20 cycles, then returns to 0 -> in_port1 stays 32'h0 and chg1 stays 0 throughout.
REQ-032 Flag-clear scenario: after a commit, pulse rd_en0 -> bit 31 clears next edge, data bits unchanged; rd_en0 on the same edge as a new commit -> bit 31 = 1 with the new data.
REQ-033 Reset-abort scenario: assert resetn=0 two cycles into a count -> outputs 0; release with input held -> commit after the full DB_CYCLES+2 latency.
REQ-034 Macro-off scenario: without IO_DEBOUNCE_EN, raw_in0 = 10'h00F before edge k -> in_port0 = 32'h8000000F after edge k+2.

Source files
------------

// File: rtl/io_input_debounce.sv
// io_input_debounce -- two independent switch/key input ports for the MEM stage.
// Each port synchronizes its raw inputs through two flops, optionally debounces
// them, and exposes {chg, zeros, stable} as a 32-bit read word. The sticky chg
// flag is set whenever a new stable value is committed. It is cleared by the
// port's read strobe, and a commit on the same edge as the strobe takes priority.
// Optional feature macro: IO_DEBOUNCE_EN. When it is defined, a change is accepted
// only after DB_CYCLES stable cycles. When it is undefined, the synchronized input
// passes straight through, and DB_CYCLES has no effect.
module io_input_debounce #(
    parameter int WIDTH     = 10,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in0,
    input  logic [WIDTH-1:0] raw_in1,
    input  logic             rd_en0,
    input  logic             rd_en1,
    output logic [31:0]      in_port0,
    output logic [31:0]      in_port1
);

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
`else
    logic w_unused_db_cfg;
    assign w_unused_db_cfg = (DB_CYCLES > 1);
`endif

    for (genvar g = 0; g < 2; g++) begin : g_port
        logic [WIDTH-1:0] w_raw;
        logic             w_rd_en;
        logic             w_commit;
        logic [WIDTH-1:0] r_s1;
        logic [WIDTH-1:0] r_s2;
        logic [WIDTH-1:0] r_stable;
        logic             r_chg;

        assign w_raw   = (g == 0) ? raw_in0 : raw_in1;
        assign w_rd_en = (g == 0) ? rd_en0  : rd_en1;

`ifdef IO_DEBOUNCE_EN
        logic [WIDTH-1:0] r_cand;
        logic [CNT_W-1:0] r_cnt;

        // A commit happens when the candidate has been held for DB_CYCLES cycles
        // and differs from the currently accepted value.
        assign w_commit = (r_s2 == r_cand) && (r_cand != r_stable) && (r_cnt == CNT_MAX);

        // Synchronizer, candidate tracking, saturating stability counter and commit.
        always_ff @(posedge clock) begin
            if (!resetn) begin
                r_s1     <= '0;
                r_s2     <= '0;
                r_cand   <= '0;
                r_cnt    <= '0;
                r_stable <= '0;
            end else begin
                r_s1 <= w_raw;
                r_s2 <= r_s1;
                if (r_s2 != r_cand) begin
                    // A bounce or a new value restarts counting.
                    r_cand <= r_s2;
                    r_cnt  <= '0;
                end else if (r_cand == r_stable) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_stable <= r_cand;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
`else
        // Any difference between the synchronized input and the held value is a change.
        assign w_commit = (r_s2 != r_stable);

        // Two-flop synchronizer, followed by a direct update of the stable value.
        always_ff @(posedge clock) begin
            if (!resetn) begin
                r_s1     <= '0;
                r_s2     <= '0;
                r_stable <= '0;
            end else begin
                r_s1     <= w_raw;
                r_s2     <= r_s1;
                r_stable <= r_s2;
            end
        end
`endif

        // Sticky change flag: set on commit, cleared by a read, with set taking priority.
        always_ff @(posedge clock) begin
            if (!resetn) begin
                r_chg <= 1'b0;
            end else if (w_commit) begin
                r_chg <= 1'b1;
            end else if (w_rd_en) begin
                r_chg <= 1'b0;
            end else begin
                r_chg <= r_chg;
            end
        end
    end

    assign in_port0 = {g_port[0].r_chg, 31'(g_port[0].r_stable)};
    assign in_port1 = {g_port[1].r_chg, 31'(g_port[1].r_stable)};

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with WIDTH=10 and DB_CYCLES=4.
// The expected latency follows the IO_DEBOUNCE_EN build option.
module tb_io_input_debounce;

    localparam int WIDTH = 10;
    localparam int DB    = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic             clock = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] raw_in0;
    logic [WIDTH-1:0] raw_in1;
    logic             rd_en0;
    logic             rd_en1;
    logic [31:0]      in_port0;
    logic [31:0]      in_port1;

    int n_checks = 0;
    int n_fails  = 0;

    io_input_debounce #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .raw_in0 (raw_in0),
        .raw_in1 (raw_in1),
        .rd_en0  (rd_en0),
        .rd_en1  (rd_en1),
        .in_port0(in_port0),
        .in_port1(in_port1)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // The inputs have already been changed, so the next edge is k.
    // After edges k .. k+LAT-1 the old words must hold; after edge k+LAT the new words must appear.
    task automatic expect_both(input string tag, input logic [31:0] p0_old, input logic [31:0] p0_new,
                               input logic [31:0] p1_old, input logic [31:0] p1_new);
        for (int j = 0; j <= LAT; j++) begin
            tick();
            chk_eq($sformatf("%s_p0_e%0d", tag, j), in_port0, (j < LAT) ? p0_old : p0_new);
            chk_eq($sformatf("%s_p1_e%0d", tag, j), in_port1, (j < LAT) ? p1_old : p1_new);
        end
    endtask

    initial begin
        resetn  = 1'b0;
        raw_in0 = 10'h3FF;
        raw_in1 = 10'h000;
        rd_en0  = 1'b1;
        rd_en1  = 1'b1;

        // Hold reset with the input active; the read strobes have no effect.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("reset_p0", in_port0, 32'h0000_0000);
            chk_eq("reset_p1", in_port1, 32'h0000_0000);
        end

        // Release reset and hold the input until it is committed.
        resetn = 1'b1;
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        expect_both("rel", 32'h0000_0000, 32'h8000_03FF, 32'h0000_0000, 32'h0000_0000);

        // A read clears the flag and leaves the data bits unchanged.
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        chk_eq("clr_p0", in_port0, 32'h0000_03FF);
        tick();
        chk_eq("clr_hold_p0", in_port0, 32'h0000_03FF);

        // Clean change.
        raw_in0 = 10'h155;
        expect_both("clean", 32'h0000_03FF, 32'h8000_0155, 32'h0000_0000, 32'h0000_0000);

        // A read one edge before the commit clears the flag.
        // A read on the commit edge loses to the set.
        raw_in0 = 10'h2AA;
        for (int j = 0; j <= LAT; j++) begin
            rd_en0 = (j >= LAT - 1) ? 1'b1 : 1'b0;
            tick();
            if (j < LAT - 1) begin
                chk_eq($sformatf("setwin_pre_e%0d", j), in_port0, 32'h8000_0155);
            end else if (j == LAT - 1) begin
                chk_eq("setwin_clr", in_port0, 32'h0000_0155);
            end else begin
                chk_eq("setwin_commit", in_port0, 32'h8000_02AA);
            end
        end
        rd_en0 = 1'b0;
        tick();
        chk_eq("setwin_hold", in_port0, 32'h8000_02AA);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        chk_eq("setwin_read", in_port0, 32'h0000_02AA);

`ifdef IO_DEBOUNCE_EN
        // Bounce on port 1 must never commit, and port 0 must not be disturbed.
        for (int i = 0; i < 20; i++) begin
            raw_in1 = ((i / 2) % 2 == 0) ? 10'h001 : 10'h000;
            tick();
            chk_eq($sformatf("bounce_p1_c%0d", i), in_port1, 32'h0000_0000);
            chk_eq($sformatf("bounce_p0_c%0d", i), in_port0, 32'h0000_02AA);
        end
        raw_in1 = 10'h000;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk_eq($sformatf("bounce_end_p1_c%0d", i), in_port1, 32'h0000_0000);
        end
`endif

        // Simultaneous changes on both ports commit independently.
        raw_in0 = 10'h0F0;
        raw_in1 = 10'h30C;
        expect_both("both", 32'h0000_02AA, 32'h8000_00F0, 32'h0000_0000, 32'h8000_030C);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        chk_eq("indep_clr_p0", in_port0, 32'h0000_00F0);
        chk_eq("indep_keep_p1", in_port1, 32'h8000_030C);

        // Reset two cycles into a count aborts it.
        // After release, the held inputs are debounced again in full.
        raw_in0 = 10'h111;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        resetn = 1'b0;
        rd_en1 = 1'b1;
        tick();
        chk_eq("abort_p0", in_port0, 32'h0000_0000);
        chk_eq("abort_p1", in_port1, 32'h0000_0000);
        resetn = 1'b1;
        rd_en1 = 1'b0;
        expect_both("abort_rel", 32'h0000_0000, 32'h8000_0111, 32'h0000_0000, 32'h8000_030C);

        // Low-nibble pattern on port 0.
        rd_en0  = 1'b1;
        rd_en1  = 1'b1;
        tick();
        rd_en0  = 1'b0;
        rd_en1  = 1'b0;
        raw_in0 = 10'h00F;
        expect_both("nib", 32'h0000_0111, 32'h8000_000F, 32'h0000_030C, 32'h0000_030C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
